// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    // Which redirect source won arbitration this cycle
    typedef enum logic [1:0] {
        NONE = 2'd0,
        BR   = 2'd1,
        JR   = 2'd2,
        J    = 2'd3
    } redirect_src_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_redirect_arb.sv
// Priority select among redirect sources: EX branch beats ID jumps, since the
// branch is older and squashes whatever instruction sits in ID.
module fetch_redirect_arb
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jr,
    input  logic [XLEN-1:0] jr_target,
    input  logic            j,
    input  logic [XLEN-1:0] j_target,
    output logic            redirect,
    output logic [XLEN-1:0] target,
    output redirect_src_e   src,
    output logic            misaligned
);

    logic [XLEN-1:0] raw_target;

    // Select the winning source and its raw target
    always_comb begin
        src        = NONE;
        raw_target = '0;
        if (br_taken) begin
            src        = BR;
            raw_target = br_target;
        end else if (jr) begin
            src        = JR;
            raw_target = jr_target;
        end else if (j) begin
            src        = J;
            raw_target = j_target;
        end
    end

    // Word-align the target; flag the dropped low bits
    always_comb begin
        redirect   = br_taken | jr | j;
        target     = {raw_target[XLEN-1:2], 2'b00};
        misaligned = redirect && (raw_target[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC, req/ack memory handshake, redirect kill
// handling, stall hold buffer and the IF/ID pipeline register.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            jr_i,
    input  logic [XLEN-1:0] jr_target_i,
    input  logic            j_i,
    input  logic [XLEN-1:0] j_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_instr_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] pc_o,
    output logic            misalign_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic [XLEN-1:0] hbuf_instr_q, hbuf_instr_d;
    logic [XLEN-1:0] hbuf_pc_q, hbuf_pc_d;
    logic            ifv_q, ifv_d;
    logic [XLEN-1:0] ifi_q, ifi_d;
    logic [XLEN-1:0] ifp_q, ifp_d;
    logic            mis_q, mis_d;

    logic            redirect;
    logic [XLEN-1:0] rd_target;
    redirect_src_e   rd_src;
    logic            rd_mis;

    fetch_redirect_arb #(.XLEN(XLEN)) u_arb (
        .br_taken   (br_taken_i),
        .br_target  (br_target_i),
        .jr         (jr_i),
        .jr_target  (jr_target_i),
        .j          (j_i),
        .j_target   (j_target_i),
        .redirect   (redirect),
        .target     (rd_target),
        .src        (rd_src),
        .misaligned (rd_mis)
    );

    // Next-state, PC, buffers and IF/ID update
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        hbuf_instr_d = hbuf_instr_q;
        hbuf_pc_d    = hbuf_pc_q;
        ifv_d        = ifv_q;
        ifi_d        = ifi_q;
        ifp_d        = ifp_q;
        mis_d        = mis_q | ((rd_src != NONE) & rd_mis);

        // A redirect squashes whatever IF/ID holds, stall or not
        if (redirect) ifv_d = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = REQ;
                if (redirect) pc_d = rd_target;
            end
            REQ: begin
                if (imem_ack_i) begin
                    if (redirect) begin
                        pc_d = rd_target;
                    end else if (!stall_i) begin
                        ifv_d = 1'b1;
                        ifi_d = imem_rdata_i;
                        ifp_d = pc_q;
                        pc_d  = pc_q + XLEN'(4);
                    end else begin
                        // Memory already returned the word; park it until ID frees up
                        hbuf_instr_d = imem_rdata_i;
                        hbuf_pc_d    = pc_q;
                        pc_d         = pc_q + XLEN'(4);
                        state_d      = HOLD;
                    end
                end else if (redirect) begin
                    // Request in flight cannot be withdrawn; remember where to go
                    pend_d  = rd_target;
                    state_d = KILL;
                end else if (!stall_i) begin
                    ifv_d = 1'b0;
                end
            end
            KILL: begin
                if (redirect) pend_d = rd_target;
                if (imem_ack_i) begin
                    pc_d    = redirect ? rd_target : pend_q;
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d         = rd_target;
                    hbuf_instr_d = '0;
                    hbuf_pc_d    = '0;
                    state_d      = REQ;
                end else if (!stall_i) begin
                    ifv_d   = 1'b1;
                    ifi_d   = hbuf_instr_q;
                    ifp_d   = hbuf_pc_q;
                    state_d = REQ;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            pend_q       <= '0;
            hbuf_instr_q <= '0;
            hbuf_pc_q    <= '0;
            ifv_q        <= 1'b0;
            ifi_q        <= '0;
            ifp_q        <= '0;
            mis_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            hbuf_instr_q <= hbuf_instr_d;
            hbuf_pc_q    <= hbuf_pc_d;
            ifv_q        <= ifv_d;
            ifi_q        <= ifi_d;
            ifp_q        <= ifp_d;
            mis_q        <= mis_d;
        end
    end

    // Outputs; in KILL the address stays on the abandoned request until ack
    always_comb begin
        imem_req_o  = (state_q == REQ) || (state_q == KILL);
        imem_addr_o = pc_q;
        if_valid_o  = ifv_q;
        if_instr_o  = ifi_q;
        if_pc_o     = ifp_q;
        pc_o        = pc_q;
        misalign_o  = mis_q;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl. Memory returns the fetch address as data.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        jr_i;
    logic [31:0] jr_target_i;
    logic        j_i;
    logic [31:0] j_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic [31:0] pc_o;
    logic        misalign_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign imem_rdata_i = imem_addr_o;

    fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall_i      (stall_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .jr_i         (jr_i),
        .jr_target_i  (jr_target_i),
        .j_i          (j_i),
        .j_target_i   (j_target_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .if_valid_o   (if_valid_o),
        .if_instr_o   (if_instr_o),
        .if_pc_o      (if_pc_o),
        .pc_o         (pc_o),
        .misalign_o   (misalign_o)
    );

    task automatic clear_inputs();
        stall_i     = 1'b0;
        br_taken_i  = 1'b0;
        br_target_i = '0;
        jr_i        = 1'b0;
        jr_target_i = '0;
        j_i         = 1'b0;
        j_target_i  = '0;
        imem_ack_i  = 1'b0;
    endtask

    // Pulse reset, leave the DUT in REQ at a negedge with ack low
    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear_inputs();
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({imem_req_o, if_valid_o, misalign_o} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: req/valid/mis=%b expected 000", {imem_req_o, if_valid_o, misalign_o});
        end
        tests_run++;
        if ({pc_o, if_pc_o, if_instr_o} !== 96'h0) begin
            tests_failed++;
            $display("FAIL reset_regs: pc=%h if_pc=%h if_instr=%h expected 0", pc_o, if_pc_o, if_instr_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        tests_run++;
        if (imem_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL boot_no_req: req=%b expected 0", imem_req_o);
        end
    endtask

    // Continues from test_reset: zero-wait memory, then a 4-cycle stall at PC 0x10
    task automatic test_zero_wait_and_stall();
        @(negedge clk);
        tests_run++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL first_req: req=%b addr=%h expected 1/00000000", imem_req_o, imem_addr_o);
        end
        imem_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (if_valid_o !== 1'b1 || if_pc_o !== 32'(4*i) || if_instr_o !== 32'(4*i)) begin
                tests_failed++;
                $display("FAIL stream_%0d: valid=%b pc=%h instr=%h expected 1/%h/%h",
                         i, if_valid_o, if_pc_o, if_instr_o, 32'(4*i), 32'(4*i));
            end
        end
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (if_valid_o !== 1'b1 || if_pc_o !== 32'hC || if_instr_o !== 32'hC ||
                imem_req_o !== 1'b0 || pc_o !== 32'h14) begin
                tests_failed++;
                $display("FAIL stall_hold_%0d: valid=%b if_pc=%h instr=%h req=%b pc=%h expected 1/c/c/0/14",
                         i, if_valid_o, if_pc_o, if_instr_o, imem_req_o, pc_o);
            end
        end
        stall_i = 1'b0;
        @(negedge clk);
        tests_run++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h10 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h14) begin
            tests_failed++;
            $display("FAIL stall_release: valid=%b if_pc=%h req=%b addr=%h expected 1/10/1/14",
                     if_valid_o, if_pc_o, imem_req_o, imem_addr_o);
        end
        @(negedge clk);
        tests_run++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h14 || if_instr_o !== 32'h14) begin
            tests_failed++;
            $display("FAIL after_hold: valid=%b if_pc=%h instr=%h expected 1/14/14", if_valid_o, if_pc_o, if_instr_o);
        end
    endtask

    task automatic test_slow_mem();
        logic [31:0] exp_pc;
        logic        prev_ack;
        do_reset();
        exp_pc   = 32'h0;
        prev_ack = 1'b0;
        for (int c = 0; c < 12; c++) begin
            imem_ack_i = (c % 3 == 2);
            @(negedge clk);
            prev_ack = imem_ack_i;
            tests_run++;
            if (prev_ack) begin
                if (if_valid_o !== 1'b1 || if_pc_o !== exp_pc || imem_addr_o !== exp_pc + 32'd4) begin
                    tests_failed++;
                    $display("FAIL slow_ack_%0d: valid=%b if_pc=%h addr=%h expected 1/%h/%h",
                             c, if_valid_o, if_pc_o, imem_addr_o, exp_pc, exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
            end else begin
                if (if_valid_o !== 1'b0 || imem_addr_o !== exp_pc) begin
                    tests_failed++;
                    $display("FAIL slow_wait_%0d: valid=%b addr=%h expected 0/%h", c, if_valid_o, imem_addr_o, exp_pc);
                end
            end
        end
    endtask

    task automatic test_branch_priority();
        do_reset();
        imem_ack_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        br_taken_i  = 1'b1;
        br_target_i = 32'h100;
        j_i         = 1'b1;
        j_target_i  = 32'h200;
        @(negedge clk);
        tests_run++;
        if (if_valid_o !== 1'b0 || imem_addr_o !== 32'h100 || imem_req_o !== 1'b1 || misalign_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL br_over_j: valid=%b addr=%h req=%b mis=%b expected 0/100/1/0",
                     if_valid_o, imem_addr_o, imem_req_o, misalign_o);
        end
        clear_inputs();
        imem_ack_i = 1'b1;
        @(negedge clk);
        tests_run++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100) begin
            tests_failed++;
            $display("FAIL br_fetch: valid=%b if_pc=%h expected 1/100", if_valid_o, if_pc_o);
        end
    endtask

    task automatic test_kill();
        do_reset();
        imem_ack_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        imem_ack_i  = 1'b0;
        jr_i        = 1'b1;
        jr_target_i = 32'h40;
        @(negedge clk);
        tests_run++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8 || if_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL kill_enter: req=%b addr=%h valid=%b expected 1/8/0", imem_req_o, imem_addr_o, if_valid_o);
        end
        jr_i = 1'b0;
        @(negedge clk);
        tests_run++;
        if (imem_addr_o !== 32'h8 || if_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL kill_wait: addr=%h valid=%b expected 8/0", imem_addr_o, if_valid_o);
        end
        imem_ack_i = 1'b1;
        @(negedge clk);
        tests_run++;
        if (imem_addr_o !== 32'h40 || if_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL kill_discard: addr=%h valid=%b expected 40/0", imem_addr_o, if_valid_o);
        end
        @(negedge clk);
        tests_run++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h40 || if_instr_o !== 32'h40) begin
            tests_failed++;
            $display("FAIL kill_resume: valid=%b if_pc=%h instr=%h expected 1/40/40", if_valid_o, if_pc_o, if_instr_o);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        imem_ack_i = 1'b1;
        j_i        = 1'b1;
        j_target_i = 32'h102;
        @(negedge clk);
        tests_run++;
        if (imem_addr_o !== 32'h100 || misalign_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL misalign_set: addr=%h mis=%b expected 100/1", imem_addr_o, misalign_o);
        end
        j_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (misalign_o !== 1'b1 || if_pc_o !== 32'h104) begin
            tests_failed++;
            $display("FAIL misalign_sticky: mis=%b if_pc=%h expected 1/104", misalign_o, if_pc_o);
        end
        do_reset();
        tests_run++;
        if (misalign_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL misalign_clear: mis=%b expected 0", misalign_o);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        imem_ack_i  = 1'b1;
        br_taken_i  = 1'b1;
        br_target_i = 32'hFFFF_FFFC;
        @(negedge clk);
        br_taken_i = 1'b0;
        @(negedge clk);
        tests_run++;
        if (if_pc_o !== 32'hFFFF_FFFC || imem_addr_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL pc_wrap: if_pc=%h addr=%h expected fffffffc/0", if_pc_o, imem_addr_o);
        end
    endtask

    task automatic test_reset_mid_kill();
        do_reset();
        br_taken_i  = 1'b1;
        br_target_i = 32'h80;
        @(negedge clk);
        br_taken_i = 1'b0;
        tests_run++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL kill_before_rst: req=%b addr=%h expected 1/0", imem_req_o, imem_addr_o);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0 || pc_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset: req=%b valid=%b pc=%h expected 0/0/0", imem_req_o, if_valid_o, pc_o);
        end
        @(negedge clk);
        reset_n    = 1'b1;
        imem_ack_i = 1'b1;
        @(negedge clk);
        tests_run++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || if_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_req: req=%b addr=%h valid=%b expected 1/0/0", imem_req_o, imem_addr_o, if_valid_o);
        end
        @(negedge clk);
        tests_run++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL restart_fetch: valid=%b if_pc=%h expected 1/0", if_valid_o, if_pc_o);
        end
    endtask

    initial begin
        reset_n = 1'b1;
        clear_inputs();
        test_reset();
        test_zero_wait_and_stall();
        test_slow_mem();
        test_branch_priority();
        test_kill();
        test_misalign();
        test_wrap();
        test_reset_mid_kill();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
